// File: rtl/instr_load_ctrl.sv
// Boot-time loader: streams the transmitter's program image into the CPU
// instruction memory write port and holds the CPU until the image is complete.
module instr_load_ctrl #(
  parameter int IWIDTH  = 32,
  parameter int DEPTH   = 36,
  parameter int AWIDTH  = 6,
  parameter int TIMEOUT = 16
) (
  input  logic              lc_clk,
  input  logic              lc_rst,
  input  logic              lc_i_start,
  output logic              lc_o_syn,
  input  logic [IWIDTH-1:0] lc_i_instr,
  input  logic              lc_i_ack,
  input  logic              lc_i_last,
  output logic              lc_o_wr_en,
  output logic [AWIDTH-1:0] lc_o_wr_addr,
  output logic [IWIDTH-1:0] lc_o_wr_data,
  output logic              lc_o_cpu_hold,
  output logic              lc_o_done,
  output logic [1:0]        lc_o_err,
  output logic [AWIDTH:0]   lc_o_count
);

  localparam int TWIDTH = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [AWIDTH:0]   COUNT_LAST = (AWIDTH+1)'(DEPTH-1);
  localparam logic [TWIDTH-1:0] TMO_LAST   = TWIDTH'(TIMEOUT-1);
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_TMO  = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic [TWIDTH-1:0] tmo_q, tmo_d;
  logic              wr_en_q, wr_en_d;
  logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [IWIDTH-1:0] wr_data_q, wr_data_d;
  logic [1:0]        err_q, err_d;

  logic streaming, accept, final_word, tmo_hit;

  assign streaming  = (state_q == S_STREAM);
  assign accept     = streaming && lc_i_ack;
  assign final_word = lc_i_last || (count_q == COUNT_LAST);
  assign tmo_hit    = streaming && !lc_i_ack && (tmo_q == TMO_LAST);

  always_ff @(posedge lc_clk or negedge lc_rst) begin
    if (!lc_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (lc_i_start) state_d = S_STREAM;
      S_STREAM: begin
        // A last marker takes priority over the depth limit on the same word.
        if (accept) begin
          if (lc_i_last)                   state_d = S_DONE;
          else if (count_q == COUNT_LAST)  state_d = S_ERR;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lc_o_syn      = streaming && !(lc_i_ack && final_word);
    lc_o_cpu_hold = (state_q != S_DONE);
    lc_o_done     = (state_q == S_DONE);
  end

  always_comb begin
    count_d   = count_q;
    tmo_d     = tmo_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    if (!streaming) begin
      if (lc_i_start) begin
        count_d = '0;
        tmo_d   = '0;
        err_d   = ERR_NONE;
      end
    end else if (lc_i_ack) begin
      wr_en_d   = 1'b1;
      wr_addr_d = count_q[AWIDTH-1:0];
      wr_data_d = lc_i_instr;
      count_d   = count_q + 1'b1;
      tmo_d     = '0;
      if (!lc_i_last && (count_q == COUNT_LAST)) err_d = ERR_OVF;
    end else if (tmo_hit) begin
      tmo_d = '0;
      err_d = ERR_TMO;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge lc_clk or negedge lc_rst) begin
    if (!lc_rst) begin
      count_q   <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= ERR_NONE;
    end else begin
      count_q   <= count_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign lc_o_wr_en   = wr_en_q;
  assign lc_o_wr_addr = wr_addr_q;
  assign lc_o_wr_data = wr_data_q;
  assign lc_o_err     = err_q;
  assign lc_o_count   = count_q;

endmodule

// File: tb/tb_instr_load_ctrl.sv
// Bench for instr_load_ctrl: transmitter model drives the handshake, a
// transaction-level reference model predicts every output each cycle.
module tb_instr_load_ctrl;
  localparam int IWIDTH  = 32;
  localparam int DEPTH   = 36;
  localparam int AWIDTH  = 6;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              ack = 1'b0;
  logic              last = 1'b0;
  logic [IWIDTH-1:0] instr = '0;
  logic              syn, wr_en, cpu_hold, done;
  logic [AWIDTH-1:0] wr_addr;
  logic [IWIDTH-1:0] wr_data;
  logic [1:0]        err;
  logic [AWIDTH:0]   count;

  always #5 clk = ~clk;

  instr_load_ctrl #(.IWIDTH(IWIDTH), .DEPTH(DEPTH), .AWIDTH(AWIDTH), .TIMEOUT(TIMEOUT)) dut (
    .lc_clk(clk), .lc_rst(rst_n), .lc_i_start(start), .lc_o_syn(syn),
    .lc_i_instr(instr), .lc_i_ack(ack), .lc_i_last(last),
    .lc_o_wr_en(wr_en), .lc_o_wr_addr(wr_addr), .lc_o_wr_data(wr_data),
    .lc_o_cpu_hold(cpu_hold), .lc_o_done(done), .lc_o_err(err), .lc_o_count(count)
  );

  int vectors = 0;
  int miscompares = 0;
  int writes_seen = 0;
  logic [IWIDTH-1:0] img [64];

  // transmitter model
  int tx_depth = DEPTH, tx_idx = 0, tx_hold = 0, tx_pct = 100, tx_streak = 0;
  bit tx_mute = 0, tx_alt = 0, tx_phase = 0, tx_spur = 0, syn_prev = 0;

  // reference model
  bit                m_streaming, m_done, m_wr_pending;
  logic [1:0]        m_err;
  int                m_count, m_idle, m_wr_addr;
  logic [IWIDTH-1:0] m_wr_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_streaming = 0; m_done = 0; m_wr_pending = 0; m_err = 2'b00;
    m_count = 0; m_idle = 0; m_wr_addr = 0; m_wr_data = '0;
  endtask

  task automatic model_step(input bit st, input bit a, input bit l, input logic [IWIDTH-1:0] d);
    m_wr_pending = 0;
    if (m_streaming) begin
      if (a) begin
        m_wr_pending = 1; m_wr_addr = m_count; m_wr_data = d;
        m_count++; m_idle = 0;
        if (l) begin m_streaming = 0; m_done = 1; end
        else if (m_count == DEPTH) begin m_streaming = 0; m_err = 2'b10; end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin m_streaming = 0; m_err = 2'b01; end
      end
    end else if (st) begin
      m_streaming = 1; m_count = 0; m_idle = 0; m_err = 2'b00; m_done = 0;
    end
  endtask

  task automatic check_regs();
    if (wr_en === 1'b1) writes_seen++;
    chk("wr_en", wr_en, m_wr_pending);
    if (m_wr_pending) begin
      chk("wr_addr", wr_addr, m_wr_addr);
      chk("wr_data", wr_data, m_wr_data);
    end
    chk("done", done, m_done);
    chk("cpu_hold", cpu_hold, !m_done);
    chk("err", err, m_err);
    chk("count", count, m_count);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".syn"}, syn, 0);
    chk({tag, ".wr_en"}, wr_en, 0);
    chk({tag, ".wr_addr"}, wr_addr, 0);
    chk({tag, ".wr_data"}, wr_data, 0);
    chk({tag, ".cpu_hold"}, cpu_hold, 1);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".count"}, count, 0);
  endtask

  // One clock cycle, entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit st);
    bit emit, exp_syn;
    emit = 0;
    if (syn_prev && !tx_mute) begin
      if (tx_hold > 0) tx_hold--;
      else if (tx_alt) begin tx_phase = !tx_phase; emit = tx_phase; end
      else emit = ($urandom_range(0, 99) < tx_pct) || (tx_streak >= 4);
      tx_streak = emit ? 0 : tx_streak + 1;
    end
    ack = emit;
    instr = $urandom;
    last = 1'($urandom_range(0, 1));
    if (emit) begin
      instr = img[tx_idx];
      last = (tx_idx == tx_depth - 1);
      tx_idx++;
    end else if (tx_spur) begin
      ack = 1'b1;
    end
    start = st;
    #1;
    exp_syn = m_streaming && !(ack && (last || m_count == DEPTH - 1));
    chk("syn", syn, exp_syn);
    syn_prev = syn;
    model_step(st, ack, last, instr);
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic run_load(input int budget, input int mid_start);
    int n;
    writes_seen = 0; tx_idx = 0; tx_streak = 0; tx_phase = 0;
    cycle(1);
    n = 0;
    while ((m_streaming || m_wr_pending) && n < budget) begin
      cycle(n == mid_start);
      n++;
    end
    tx_hold = 0;
  endtask

  task automatic expect_outcome(input string tag, input bit d, input logic [1:0] e, input int w);
    chk({tag, ".done"}, done, d);
    chk({tag, ".hold"}, cpu_hold, !d);
    chk({tag, ".err"}, err, e);
    chk({tag, ".writes"}, writes_seen, w);
    chk({tag, ".count"}, count, w);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) img[i] = $urandom;
    model_reset();
    #2;
    check_reset("reset");
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    tx_depth = DEPTH;
    run_load(100, -1);
    expect_outcome("full", 1, 2'b00, DEPTH);

    tx_spur = 1;
    repeat (3) cycle(0);
    tx_spur = 0;
    chk("spur.count", count, DEPTH);

    run_load(100, 12);
    expect_outcome("reload_midstart", 1, 2'b00, DEPTH);

    tx_mute = 1;
    run_load(40, -1);
    tx_mute = 0;
    expect_outcome("timeout", 0, 2'b01, 0);

    tx_hold = TIMEOUT - 2;
    run_load(100, -1);
    expect_outcome("stall_ok", 1, 2'b00, DEPTH);

    tx_hold = TIMEOUT - 1;
    run_load(100, -1);
    expect_outcome("stall_tmo", 0, 2'b01, 0);

    tx_depth = DEPTH + 4;
    run_load(100, -1);
    expect_outcome("overflow", 0, 2'b10, DEPTH);

    tx_depth = 1;
    run_load(100, -1);
    expect_outcome("one_word", 1, 2'b00, 1);

    tx_depth = DEPTH; tx_alt = 1;
    run_load(200, -1);
    tx_alt = 0;
    expect_outcome("gapped", 1, 2'b00, DEPTH);

    writes_seen = 0; tx_idx = 0;
    cycle(1);
    n = 0;
    while (writes_seen < 10 && n < 100) begin cycle(0); n++; end
    chk("midreset.writes", writes_seen, 10);
    #2 rst_n = 1'b0;
    #1;
    check_reset("midreset");
    model_reset();
    syn_prev = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_load(100, -1);
    expect_outcome("after_reset", 1, 2'b00, DEPTH);

    for (int r = 0; r < 12; r++) begin
      case ($urandom_range(0, 2))
        0:       tx_depth = DEPTH;
        1:       tx_depth = DEPTH + 4;
        default: tx_depth = $urandom_range(1, DEPTH);
      endcase
      tx_pct = $urandom_range(40, 100);
      run_load(400, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : -1);
    end
    tx_pct = 100;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
